// File: rtl/mul_div_unit_if.sv
// Bus between the instruction pipeline (master) and the multiply/divide unit (slave).
//   start    master->slave  launch mult/multu/div/divu
//   move_to  master->slave  write HI/LO from a (mthi/mtlo)
//   sel      master->slave  0 MUL, 1 MULU, 2 DIV, 3 DIVU, 4 HI, 5 LO, 7 none
//   a, b     master->slave  rs / rt operands
//   busy     slave->master  operation in flight
//   rdata    slave->master  mfhi/mflo read data
//   cancel   master->slave  flush of the in-flight operation (only with MDU_CANCEL_EN)
interface mul_div_unit_if;
    logic        start;
    logic        move_to;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] rdata;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    modport master (
`ifdef MDU_CANCEL_EN
        output cancel,
`endif
        output start, move_to, sel, a, b,
        input  busy, rdata
    );

    modport slave (
`ifdef MDU_CANCEL_EN
        input  cancel,
`endif
        input  start, move_to, sel, a, b,
        output busy, rdata
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multiply/divide unit for the EX stage. Owns HI/LO, executes mult/multu/div/divu with a
// fixed busy countdown, and services mthi/mtlo/mfhi/mflo.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    mul_div_unit_if.slave (start, move_to, sel, a, b -> busy, rdata [, cancel])
// Parameters: MUL_CYCLES / DIV_CYCLES = busy duration of multiplies / divides (1..15).
// Optional feature: define MDU_CANCEL_EN to add the cancel input, which aborts an operation.
module mul_div_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam logic [2:0] SelMul  = 3'd0;
    localparam logic [2:0] SelMulu = 3'd1;
    localparam logic [2:0] SelDiv  = 3'd2;
    localparam logic [2:0] SelDivu = 3'd3;
    localparam logic [2:0] SelHi   = 3'd4;
    localparam logic [2:0] SelLo   = 3'd5;
    localparam logic [3:0] MulCnt  = 4'(MUL_CYCLES);
    localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

    logic [3:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        idle;
    logic        cancel;

`ifdef MDU_CANCEL_EN
    assign cancel = bus.cancel;
`else
    assign cancel = 1'b0;
`endif

    assign idle = (count_q == 4'd0);

    // Arithmetic datapath
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s, b_s, div_s, quot_s, rem_s;
    logic        [31:0] div_u, quot_u, rem_u;
    logic               b_zero, div_ovf;

    assign a_s    = $signed(bus.a);
    assign b_s    = $signed(bus.b);
    assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};
    assign b_zero = (bus.b == 32'd0);
    // Most-negative / -1 overflows; dividing by 1 instead gives the natural wrapped result
    // (quotient = dividend, remainder = 0). A zero divisor is likewise replaced so the
    // datapath never divides by zero; that result is discarded anyway.
    assign div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    assign div_s   = (b_zero || div_ovf) ? 32'sd1 : b_s;
    assign div_u   = b_zero ? 32'd1 : bus.b;
    assign quot_s  = a_s / div_s;
    assign rem_s   = a_s % div_s;
    assign quot_u  = bus.a / div_u;
    assign rem_u   = bus.a % div_u;

    always_comb begin
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (cancel) begin
            count_d   = 4'd0;
            pend_hi_d = 32'd0;
            pend_lo_d = 32'd0;
        end else if (!idle) begin
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (bus.start) begin
            // start takes priority over move_to even when its sel is not an operation
            unique case (bus.sel)
                SelMul: begin
                    {pend_hi_d, pend_lo_d} = prod_s;
                    count_d = MulCnt;
                end
                SelMulu: begin
                    {pend_hi_d, pend_lo_d} = prod_u;
                    count_d = MulCnt;
                end
                SelDiv: begin
                    // Zero divisor: commit rewrites the current HI/LO, which cannot change
                    // while busy, so they are effectively left unchanged.
                    pend_hi_d = b_zero ? hi_q : rem_s;
                    pend_lo_d = b_zero ? lo_q : quot_s;
                    count_d   = DivCnt;
                end
                SelDivu: begin
                    pend_hi_d = b_zero ? hi_q : rem_u;
                    pend_lo_d = b_zero ? lo_q : quot_u;
                    count_d   = DivCnt;
                end
                default: ;
            endcase
        end else if (bus.move_to) begin
            if (bus.sel == SelHi) hi_d = bus.a;
            if (bus.sel == SelLo) lo_d = bus.a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign bus.busy = !idle;

    always_comb begin
        bus.rdata = 32'd0;
        if (bus.sel == SelHi) bus.rdata = hi_q;
        else if (bus.sel == SelLo) bus.rdata = lo_q;
    end
endmodule
